mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed data memory that answers the processor's memory-request interface: accepts one read or write request at a time, waits a fixed number of wait states, then returns a single-cycle `Ready` pulse with read data or an error flag. It is the memory end of the datapath's fetch/load/store port. Its `MemData` output feeds the instruction register and the load path. Its request inputs are driven by the control unit and the PC/ALU address path.

## Interface
- `DEPTH_LOG2`, default 8: log2 of the number of 32-bit words, 256 words by default.
- `LATENCY`, default 2: wait states between request acceptance and response; legal range 0..15.

Ports:
- `Clk` in 1: clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `MemReq` in 1: request strobe; sampled only in IDLE.
- `MemWR` in 1: 1 = write, 0 = read; sampled with `MemReq`.
- `Address` in 32: byte address; sampled with `MemReq`.
- `WriteData` in 32: write data; sampled with `MemReq`.
- `MemData` out 32: read data; valid while `Ready`=1.
- `Ready` out 1: one-cycle response pulse.
- `Busy` out 1: high while a request is outstanding.
- `AddrErr` out 1: qualifies `Ready`; 1 = request rejected.

## Operation
- FSM states: IDLE, WAIT, RESP. Cycle counter is 4 bits.
- IDLE (`Busy`=0):
  - `MemReq`=1 at an edge registers `MemWR`, `Address` and `WriteData`.
  - The same edge loads the counter with `LATENCY` and moves to WAIT.
  - `MemReq`=0 stays in IDLE.
- WAIT (`Busy`=1):
  - Counter ≠ 0: decrement.
  - Counter = 0: perform the access and go to RESP.
- RESP (`Busy`=1): go to IDLE unconditionally.
- `MemReq` is ignored in WAIT and RESP. There is no queueing; the requester must hold or re-issue the request.
- Error when either holds:
  - `Address[1:0]` ≠ 0 (misaligned).
  - `Address[31:DEPTH_LOG2+2]` ≠ 0 (out of range).
- Index = `Address[DEPTH_LOG2+1:2]`.
- Access at the WAIT→RESP edge. `Ready`, `AddrErr` and `MemData` are registers loaded on this edge:
  - Read, no error: `MemData` ← word[index]; `AddrErr` ← 0.
  - Write, no error: word[index] ← captured `WriteData`; `MemData` unchanged; `AddrErr` ← 0.
  - Any error: array untouched; `AddrErr` ← 1; `MemData` ← 0 for reads, unchanged for writes.
  - `Ready` ← 1.
- RESP→IDLE edge: `Ready` ← 0 and `AddrErr` ← 0. `MemData` holds its value until the next read response.
- Read after write returns the newly written word, since the write commits before any later request is accepted.
- Array contents are not cleared by `Reset`. The array contents after power-up are undefined. The bench initialises every word it reads.

## Timing
- Reset values:
  - FSM IDLE, counter 0.
  - `Ready`=0, `Busy`=0, `AddrErr`=0, `MemData`=0.
- `Reset` acts asynchronously; outputs take reset values without waiting for a clock edge.
- Request accepted at edge E0. `Busy` rises after E0.
- `Ready` rises at E(LATENCY+1) and falls at E(LATENCY+2). `Busy` also falls at E(LATENCY+2).
- `Busy` is high for LATENCY+2 cycles.
- Next request can be accepted at E(LATENCY+3) at the earliest. With `MemReq` held high, accepts are LATENCY+3 cycles apart.
- Write commit happens at E(LATENCY+1).
- `Reset` while in WAIT:
  - Captured request discarded; a pending write is never committed.
  - No `Ready` is produced.
- `Reset` while in RESP: `Ready`, `AddrErr` and `MemData` go to 0 immediately. A write already committed at E(LATENCY+1) persists.
- `LATENCY`=0: WAIT lasts one cycle; `Ready` rises at E1.

## Test plan
- Write 0xDEADBEEF to 0x10, `LATENCY`=2:
  - `Busy` high during cycles E0–E4.
  - `Ready`=1 for exactly the cycle E3–E4 with `AddrErr`=0.
  - Read of 0x10 then returns `MemData`=0xDEADBEEF during its `Ready` cycle.
  - `MemData` still 0xDEADBEEF 10 cycles later.
- Misaligned read of 0x13 → `Ready`=1, `AddrErr`=1, `MemData`=0.
- Misaligned write of 0x55 to 0x22, after word 0x20 was set to 0x1234 → `AddrErr`=1; word 0x20 still reads 0x1234.
- Range check, `DEPTH_LOG2`=8:
  - Write to 0x400 → `AddrErr`=1.
  - Write 0xCAFE to 0x3FC (last word) → `AddrErr`=0; read back 0xCAFE.
- `MemReq` held high with alternating addresses:
  - Accepts exactly every 5 cycles (`LATENCY`=2).
  - Exactly one `Ready` per accept; no extra responses.
- After 0x10 holds 0x11111111, write 0x22222222 to 0x10 and assert `Reset` asynchronously one cycle after E0 (in WAIT):
  - `Busy`=0 and `Ready`=0 immediately; no `Ready` follows.
  - Later read of 0x10 returns 0x11111111.
- Instance with `LATENCY`=0: write 0xA5A5A5A5 to 0x8 accepted at E0 → `Ready` high E1–E2; read back 0xA5A5A5A5.

Source files
------------

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Word-addressed 32-bit data memory that serves the processor's memory-request
// port. It accepts one read or write at a time, waits LATENCY cycles, then
// produces a single-cycle Ready pulse with read data or an address-error flag.
//
// Parameters:
//   DEPTH_LOG2 : log2 of the number of 32-bit words (default 8 -> 256 words)
//   LATENCY    : wait states between accept and response, 0..15 (default 2)
//
// Ports:
//   Clk       in  1  : clock, rising edge
//   Reset     in  1  : asynchronous active-high reset
//   MemReq    in  1  : request strobe, sampled only while idle
//   MemWR     in  1  : 1 = write, 0 = read, sampled with MemReq
//   Address   in  32 : byte address, sampled with MemReq
//   WriteData in  32 : write data, sampled with MemReq
//   MemData   out 32 : read data, valid while Ready = 1, held afterwards
//   Ready     out 1  : one-cycle response pulse
//   Busy      out 1  : high while a request is outstanding
//   AddrErr   out 1  : qualifies Ready, 1 = request rejected
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemReq,
  input  logic        MemWR,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] MemData,
  output logic        Ready,
  output logic        Busy,
  output logic        AddrErr
);

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_nxt;
  logic                    w_accept;
  logic                    w_access;

  logic                    r_wr;
  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;

  logic [31:0]             r_mem [DEPTH];

  logic                    w_err;
  logic [DEPTH_LOG2-1:0]   w_idx;

  logic [31:0]             r_mem_data;
  logic                    r_ready;
  logic                    r_addr_err;

  // Misaligned, or any address bit above the array's byte range set.
  assign w_err = (r_addr[1:0] != 2'b00) || ((r_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign w_idx = r_addr[DEPTH_LOG2+1:2];

  // FSM state and wait-state counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (MemReq) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = LAT_CNT;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_access    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request capture: pure data, so no reset; only meaningful after an accept.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_wr    <= MemWR;
      r_addr  <= Address;
      r_wdata <= WriteData;
    end
  end

  // Array write. A reset during WAIT forces IDLE, so w_access never fires and
  // the captured write is dropped.
  always_ff @(posedge Clk) begin
    if (w_access && r_wr && !w_err) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  // Response registers. MemData is only touched by read responses so it keeps
  // the last read value across writes and idle periods.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
      r_mem_data <= 32'd0;
    end else if (w_access) begin
      r_ready    <= 1'b1;
      r_addr_err <= w_err;
      if (!r_wr) begin
        r_mem_data <= w_err ? 32'd0 : r_mem[w_idx];
      end
    end else if (r_state == ST_RESP) begin
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
    end
  end

  assign MemData = r_mem_data;
  assign Ready   = r_ready;
  assign AddrErr = r_addr_err;
  assign Busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Scoreboard bench for mem_responder. Requests push their expected response
// (computed from a word-array model) into a queue; a monitor on the falling
// clock edge pops and compares whenever Ready is seen. A second instance with
// LATENCY = 0 is exercised directly.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int DL  = 8;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY = 2 instance
  logic        rst, req, wr;
  logic [31:0] addr, wdata, mdata;
  logic        ready, busy, aerr;

  // LATENCY = 0 instance
  logic        rst1, req1, wr1;
  logic [31:0] addr1, wdata1, mdata1;
  logic        ready1, busy1, aerr1;

  mem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .Clk(clk), .Reset(rst), .MemReq(req), .MemWR(wr), .Address(addr),
    .WriteData(wdata), .MemData(mdata), .Ready(ready), .Busy(busy), .AddrErr(aerr)
  );

  mem_responder #(.DEPTH_LOG2(DL), .LATENCY(0)) dut0 (
    .Clk(clk), .Reset(rst1), .MemReq(req1), .MemWR(wr1), .Address(addr1),
    .WriteData(wdata1), .MemData(mdata1), .Ready(ready1), .Busy(busy1), .AddrErr(aerr1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [256];
  bit          mdl_ok [256];
  logic [31:0] mdl_last = 32'd0;
  int          n_ready  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference model: a plain word array plus the last value read out.
  function automatic exp_t model(input bit w, input logic [31:0] a,
                                 input logic [31:0] d, input int acc);
    exp_t e;
    int   idx;
    e.err = ((a % 4) != 0) || (a >= (32'd4 << DL));
    idx   = e.err ? 0 : int'(a / 4);
    if (w) begin
      if (!e.err) begin
        mdl[idx]    = d;
        mdl_ok[idx] = 1'b1;
      end
    end else begin
      mdl_last = e.err ? 32'd0 : mdl[idx];
    end
    e.data = mdl_last;
    e.acc  = acc;
    return e;
  endfunction

  // Monitor / scoreboard checker
  bit   prev_rdy = 1'b0;
  int   brun     = 0;
  exp_t got_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_rdy = 1'b0;
      brun     = 0;
    end else begin
      if (busy) begin
        brun++;
      end else if (brun > 0) begin
        chk("busy_len", 32'(brun), 32'(LAT + 2));
        brun = 0;
      end
      if (ready) begin
        n_ready++;
        chk("ready_pulse_prev", 32'(prev_rdy), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_ready: unexpected response AddrErr=%b MemData=%h (t=%0t)",
                   aerr, mdata, $time);
        end else begin
          got_e = exp_q.pop_front();
          chk("addrerr", 32'(aerr), 32'(got_e.err));
          chk("memdata", mdata, got_e.data);
          chk("latency", 32'(cyc - got_e.acc), 32'(LAT + 1));
        end
      end
      prev_rdy = ready;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("resp_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    exp_q.push_back(model(w, a, d, cyc));
    wait_done();
  endtask

  initial begin
    int          base_ready;
    bit          w;
    int          kind;
    int          idx;
    logic [31:0] a;

    rst  = 1'b1; req  = 1'b0; wr  = 1'b0; addr  = '0; wdata  = '0;
    rst1 = 1'b1; req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",   32'(ready), 32'd0);
    chk("rst_busy",    32'(busy),  32'd0);
    chk("rst_addrerr", 32'(aerr),  32'd0);
    chk("rst_memdata", mdata,      32'd0);
    rst  = 1'b0;
    rst1 = 1'b0;
    @(posedge clk); #1;

    // Basic write / read-back / MemData hold
    do_req(1'b1, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 32'h10, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("memdata_hold", mdata, 32'hDEADBEEF);

    // Misaligned read
    do_req(1'b0, 32'h13, 32'h0);

    // Misaligned write leaves the neighbouring word alone
    do_req(1'b1, 32'h20, 32'h1234);
    do_req(1'b1, 32'h22, 32'h55);
    do_req(1'b0, 32'h20, 32'h0);

    // Range boundary
    do_req(1'b1, 32'h400, 32'h1);
    do_req(1'b1, 32'h3FC, 32'hCAFE);
    do_req(1'b0, 32'h3FC, 32'h0);

    // MemReq held high: accepts every LAT+3 cycles, one response each
    do_req(1'b1, 32'h40, 32'hAAAA0040);
    do_req(1'b1, 32'h44, 32'h55550044);
    wait_idle();
    base_ready = n_ready;
    req = 1'b1; wr = 1'b0; addr = 32'h40; wdata = '0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) @(posedge clk);
      else        repeat (LAT + 3) @(posedge clk);
      #1;
      exp_q.push_back(model(1'b0, addr, 32'h0, cyc));
      addr = (addr == 32'h40) ? 32'h44 : 32'h40;
      if (i == 5) req = 1'b0;
    end
    wait_done();
    repeat (4) @(posedge clk);
    #1;
    chk("held_resp_count", 32'(n_ready - base_ready), 32'd6);

    // Reset during WAIT discards the pending write
    do_req(1'b1, 32'h10, 32'h11111111);
    wait_idle();
    req = 1'b1; wr = 1'b1; addr = 32'h10; wdata = 32'h22222222;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy",  32'(busy),  32'd0);
    chk("async_rst_ready", 32'(ready), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    mdl_last = 32'd0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_busy",    32'(busy), 32'd0);
    chk("post_rst_memdata", mdata,     32'd0);
    do_req(1'b0, 32'h10, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      w    = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      idx  = (kind < 5) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
      if (kind == 0)      a = 32'(idx * 4 + int'($urandom_range(1, 3)));
      else if (kind == 1) a = 32'h400 + 32'(idx * 4);
      else if (kind == 2) a = 32'h80000000 | 32'(idx * 4);
      else                a = 32'(idx * 4);
      if (!w && kind > 2 && !mdl_ok[idx]) w = 1'b1;
      do_req(w, a, $urandom);
    end

    // LATENCY = 0 instance
    req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h8; wdata1 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req1 = 1'b0;
    chk("l0_ready_e0", 32'(ready1), 32'd0);
    chk("l0_busy_e0",  32'(busy1),  32'd1);
    @(posedge clk); #1;
    chk("l0_ready_e1",   32'(ready1), 32'd1);
    chk("l0_addrerr_e1", 32'(aerr1),  32'd0);
    @(posedge clk); #1;
    chk("l0_ready_e2", 32'(ready1), 32'd0);
    chk("l0_busy_e2",  32'(busy1),  32'd0);
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h8;
    @(posedge clk); #1;
    req1 = 1'b0;
    @(posedge clk); #1;
    chk("l0_rd_ready",   32'(ready1), 32'd1);
    chk("l0_rd_memdata", mdata1,      32'hA5A5A5A5);
    @(posedge clk); #1;

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound on run time
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
